display_scan_ctrl: RTL and testbench
====================================

# display_scan_ctrl

Time-multiplexed scan controller sharing one 7-segment decoder and one segment bus among `NUM_DIGITS` common-cathode/anode digits. It sits between the counter datapath (digit values) and the board display pins, and sequences digit enables with a blanking gap to prevent ghosting. New digit values are accepted via a load strobe and committed only at frame boundaries, so a frame never shows a mix of old and new values.

## Interface
- `NUM_DIGITS`, 4: number of scanned digits (2..8).
- `DRIVE_CYCLES`, 49500: clocks each digit is lit.
- `BLANK_CYCLES`, 500: clocks all digits are dark before each digit is lit (≥1).

- `clk_50MHz`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  scan enable; low forces display dark.
- `load`  in  1  one-cycle strobe: capture `digits` into the pending register.
- `digits`  in  4*NUM_DIGITS  packed nibbles; digit 0 = bits [3:0] (rightmost).
- `seg`  out  7  segment bus {g,f,e,d,c,b,a}, active-high.
- `digit_en`  out  NUM_DIGITS  one-hot digit select, active-high; all-zero when dark.
- `pending`  out  1  high while a loaded value awaits its frame commit.
- `frame_done`  out  1  one-cycle pulse when the last digit finishes DRIVE.

## Operation
- Registers: pending register (`4*NUM_DIGITS` bits), shadow register (displayed value), digit index, phase counter, and a 3-state FSM.
- FSM states:
  - IDLE: all outputs dark.
  - BLANK: `seg=0`, `digit_en=0`; runs `BLANK_CYCLES` clocks.
  - DRIVE: `digit_en[idx]=1`, `seg=decode(shadow[idx])`; runs `DRIVE_CYCLES` clocks.
- Transitions:
  - IDLE→BLANK when `enable=1`, with `idx=0`.
  - BLANK→DRIVE at the end of the BLANK count.
  - At the end of the DRIVE count: go to BLANK and set `idx=idx+1`.
  - If `idx=NUM_DIGITS-1` at that point: `idx` wraps to 0, `frame_done` pulses, and the frame commit happens.
- Frame commit: if `pending=1`, copy pending→shadow and clear `pending` on the same edge.
- Load handling:
  - `load=1` captures `digits` into the pending register and sets `pending`.
  - A load while already pending overwrites it; the last one wins.
  - A load in the same cycle as a frame commit is written directly to shadow; `pending` ends at 0.
- Decoder: full hex 0–F. 0→7'h3F, 1→7'h06, 9→7'h6F, A→7'h77, F→7'h71.
- `enable` deasserted in any state:
  - Next state is IDLE; `idx` and the phase counter are cleared.
  - `pending`/shadow are retained.
  - No `frame_done` pulse.
- Phase counter width is `$clog2(max(DRIVE_CYCLES, BLANK_CYCLES))`. It counts 0..N-1 and reloads 0 on each state change.

## Timing
- Reset values: state IDLE, `seg=0`, `digit_en=0`, `pending=0`, `frame_done=0`, shadow=0, pending register=0, `idx=0`.
- All outputs are registered and change on the same edge as the state change, so there is no combinational path from inputs to outputs.
- `enable` rising at edge k: BLANK from k+1; first DRIVE at k+1+`BLANK_CYCLES`.
- Digit period = `BLANK_CYCLES+DRIVE_CYCLES`; frame = `NUM_DIGITS`×period.
- `pending` rises on the edge after `load`.
- Latency from commit to new value on `seg`: the first DRIVE of digit 0, `BLANK_CYCLES` clocks after `frame_done`.
- `reset` mid-DRIVE: outputs dark immediately (asynchronous); operation resumes from IDLE after release.

## Configuration
- `LEADING_ZERO_BLANK_EN`
  - Defined: while driving a digit whose nibble is 0 and all higher-index nibbles of shadow are 0, `seg=0` while `digit_en` is still asserted. Digit 0 is never blanked, so value 0 displays as a single "0".
  - Undefined: every digit shows its decoded nibble, including leading zeros.

## Structure
- Package `display_pkg`: `SEG_W=7`, `NIBBLE_W=4`, the FSM state enum `scan_state_t` (IDLE, BLANK, DRIVE), and the 16-entry segment encoding constants.
- Sub-module `seg7_decode`: combinational nibble→segment decoder, instantiated once and fed by the `idx` mux.

## Test plan
Use `NUM_DIGITS=2`, `DRIVE_CYCLES=4`, `BLANK_CYCLES=2`.
1. Reset, `enable=1`, load 8'h31 → after the first commit, `digit_en=01`/`seg=7'h06` for 4 clocks, 2 dark clocks, then `digit_en=10`/`seg=7'h4F`. `frame_done` pulses every 12 clocks.
2. Load 8'h95 mid-frame → `pending=1`; the current frame still shows the old value; the next frame shows 5 then 9; `pending` clears on the `frame_done` edge.
3. Two loads (8'h11 then 8'h22) in one frame → only 22 is displayed; load coincident with `frame_done` → that value is displayed in the next frame, and `pending=0`.
4. Drop `enable` during DRIVE of digit 1 → next clock `digit_en=0`, `seg=0`, no `frame_done`. Re-enable → BLANK for 2 clocks, then digit 0.
5. Assert `reset` mid-DRIVE → `seg`/`digit_en` go to 0 without a clock edge; shadow=0, so after re-enable `seg=7'h3F` on both digits (undefined macro).
6. Define `LEADING_ZERO_BLANK_EN`, load 8'h07 → digit 1 enabled with `seg=0`, digit 0 shows `seg=7'h07`; load 8'h00 → digit 0 shows `seg=7'h3F`.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package display_pkg;

  localparam int unsigned SEG_W    = 7;
  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StBlank,
    StDrive
  } scan_state_t;

  // Segment patterns {g,f,e,d,c,b,a}, active-high, indexed by hex nibble.
  localparam logic [SEG_W-1:0] SegLut [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to 7-segment pattern decoder.
module seg7_decode
  import display_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble_i,
  output logic [SEG_W-1:0]    seg_o
);

  always_comb begin
    seg_o = SegLut[nibble_i];
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed digit scanner with blanking gaps and frame-aligned value commit.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses segments of leading zero digits.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DRIVE_CYCLES = 49500,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic                         clk_50MHz,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         load,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] digits,
  output logic [SEG_W-1:0]             seg,
  output logic [NUM_DIGITS-1:0]        digit_en,
  output logic                         pending,
  output logic                         frame_done
);

  localparam int unsigned MaxCycles = max_u(DRIVE_CYCLES, BLANK_CYCLES);
  localparam int unsigned CntW      = ($clog2(MaxCycles) > 0) ? $clog2(MaxCycles) : 1;
  localparam int unsigned IdxW      = $clog2(NUM_DIGITS);
  localparam int unsigned DataW     = NIBBLE_W * NUM_DIGITS;

  localparam logic [CntW-1:0] DriveLast = CntW'(DRIVE_CYCLES - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(NUM_DIGITS - 1);

  scan_state_t           state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [DataW-1:0]      pend_data_q, pend_data_d;
  logic                  pending_q, pending_d;
  logic [DataW-1:0]      shadow_q, shadow_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
  logic                  frame_done_q, frame_done_d;

  logic                  frame_end;
  logic [NIBBLE_W-1:0]   cur_nibble;
  logic [SEG_W-1:0]      dec_seg;
  logic                  lz_blank;

  // Digit mux into the single shared decoder.
  always_comb begin
    cur_nibble = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IdxW'(i)) begin
        cur_nibble = shadow_q[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  seg7_decode u_seg7_decode (
    .nibble_i (cur_nibble),
    .seg_o    (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic hi_zero;

  // Current digit and every more-significant digit zero; digit 0 always shows.
  always_comb begin
    hi_zero = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if ((IdxW'(i) >= idx_q) && (shadow_q[i*NIBBLE_W +: NIBBLE_W] != '0)) begin
        hi_zero = 1'b0;
      end
    end
    lz_blank = hi_zero && (idx_q != '0);
  end
`else
  assign lz_blank = 1'b0;
`endif

  // Scan sequencing.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    frame_end = 1'b0;
    if (!enable) begin
      state_d = StIdle;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StBlank;
          cnt_d   = '0;
          idx_d   = '0;
        end
        StBlank: begin
          if (cnt_q == BlankLast) begin
            state_d = StDrive;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StDrive: begin
          if (cnt_q == DriveLast) begin
            state_d = StBlank;
            cnt_d   = '0;
            if (idx_q == IdxLast) begin
              idx_d     = '0;
              frame_end = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Pending/shadow handling; a load coinciding with the commit bypasses to shadow.
  always_comb begin
    pend_data_d = pend_data_q;
    pending_d   = pending_q;
    shadow_d    = shadow_q;
    if (load) begin
      pend_data_d = digits;
    end
    if (frame_end) begin
      pending_d = 1'b0;
      if (load) begin
        shadow_d = digits;
      end else if (pending_q) begin
        shadow_d = pend_data_q;
      end
    end else if (load) begin
      pending_d = 1'b1;
    end
  end

  // Outputs follow the next state; shadow and idx are stable whenever DRIVE is entered or held.
  always_comb begin
    seg_d        = '0;
    digit_en_d   = '0;
    frame_done_d = frame_end;
    if (state_d == StDrive) begin
      digit_en_d = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_d;
      seg_d      = lz_blank ? '0 : dec_seg;
    end
  end

  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_data_q  <= '0;
      pending_q    <= 1'b0;
      shadow_q     <= '0;
      seg_q        <= '0;
      digit_en_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_data_q  <= pend_data_d;
      pending_q    <= pending_d;
      shadow_q     <= shadow_d;
      seg_q        <= seg_d;
      digit_en_q   <= digit_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign digit_en   = digit_en_q;
  assign pending    = pending_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed self-checking bench for display_scan_ctrl with 2 digits, DRIVE=4, BLANK=2.
module tb_display_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       load = 1'b0;
  logic [7:0] digits = 8'h00;
  logic [6:0] seg;
  logic [1:0] digit_en;
  logic       pending;
  logic       frame_done;

  int n_checks = 0;
  int n_errors = 0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LzSeg = 7'h00;
`else
  localparam logic [6:0] LzSeg = 7'h3F;
`endif

  always #5 clk = ~clk;

  display_scan_ctrl #(
    .NUM_DIGITS   (2),
    .DRIVE_CYCLES (4),
    .BLANK_CYCLES (2)
  ) dut (
    .clk_50MHz  (clk),
    .reset      (rst_n),
    .enable     (enable),
    .load       (load),
    .digits     (digits),
    .seg        (seg),
    .digit_en   (digit_en),
    .pending    (pending),
    .frame_done (frame_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frame_done(input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (frame_done) seen = 1'b1;
    end
    check("frame_done_wait", 32'(seen), 32'd1);
  endtask

  // Starts on the frame_done sample; checks one full 12-cycle frame and optionally loads.
  task automatic check_frame(input string tag, input logic [6:0] d0, input logic [6:0] d1,
                             input int la, input logic [7:0] va,
                             input int lb, input logic [7:0] vb);
    logic        pend_exp;
    logic        fd_exp;
    logic [10:0] exp;
    pend_exp = 1'b0;
    for (int i = 0; i <= 12; i++) begin
      if (i > 0) begin
        tick();
        fd_exp = (i == 12);
        if (i == 12) pend_exp = 1'b0;
        else if ((la >= 0 && i == la + 1) || (lb >= 0 && i == lb + 1)) pend_exp = 1'b1;
        if (i >= 2 && i <= 5)       exp = {1'b0, pend_exp, 2'b01, d0};
        else if (i >= 8 && i <= 11) exp = {1'b0, pend_exp, 2'b10, d1};
        else                        exp = {fd_exp, pend_exp, 2'b00, 7'h00};
        check($sformatf("%s[%0d]", tag, i),
              32'({frame_done, pending, digit_en, seg}), 32'(exp));
      end
      if (i == la) begin
        load = 1'b1;
        digits = va;
      end else if (i == lb) begin
        load = 1'b1;
        digits = vb;
      end else begin
        load = 1'b0;
      end
    end
    load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_seg", 32'(seg), 32'h0);
    check("rst_digit_en", 32'(digit_en), 32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    #10 rst_n = 1'b1;
    tick();
    tick();
    check("idle_dark", 32'({frame_done, digit_en, seg}), 32'h0);

    // Enable and first load together; value waits for the first frame commit.
    enable = 1'b1;
    load = 1'b1;
    digits = 8'h31;
    tick();
    load = 1'b0;
    check("load_pending", 32'(pending), 32'h1);
    check("first_blank", 32'({digit_en, seg}), 32'h0);
    wait_frame_done(40);
    check("commit_clears_pending", 32'(pending), 32'h0);

    check_frame("f31", 7'h06, 7'h4F, 3, 8'h95, -1, 8'h00);
    check_frame("f95", 7'h6D, 7'h6F, 2, 8'h11, 6, 8'h22);
    check_frame("f22", 7'h5B, 7'h5B, 11, 8'h47, -1, 8'h00);
    check_frame("f47", 7'h07, 7'h66, -1, 8'h00, -1, 8'h00);

    // Drop enable while digit 1 is driving.
    repeat (8) tick();
    check("pre_drop_d1", 32'({digit_en, seg}), 32'({2'b10, 7'h66}));
    enable = 1'b0;
    tick();
    check("en_drop_dark", 32'({frame_done, digit_en, seg}), 32'h0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("idle_no_fd[%0d]", i), 32'({frame_done, digit_en, seg}), 32'h0);
    end
    enable = 1'b1;
    tick();
    check("reen_blank0", 32'({frame_done, digit_en, seg}), 32'h0);
    tick();
    check("reen_blank1", 32'({frame_done, digit_en, seg}), 32'h0);
    tick();
    check("reen_d0", 32'({digit_en, seg}), 32'({2'b01, 7'h07}));
    tick();

    // Asynchronous reset in the middle of a DRIVE phase.
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_dark", 32'({digit_en, seg}), 32'h0);
    check("async_rst_pending", 32'(pending), 32'h0);
    enable = 1'b0;
    #10 rst_n = 1'b1;
    enable = 1'b1;
    tick();
    check("post_rst_blank", 32'({frame_done, digit_en, seg}), 32'h0);
    check_frame("f00", 7'h3F, LzSeg, 3, 8'h07, -1, 8'h00);
    check_frame("f07", 7'h07, LzSeg, 3, 8'h00, -1, 8'h00);
    check_frame("f00b", 7'h3F, LzSeg, -1, 8'h00, -1, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
